// File: rtl/aes_pkg.sv
// Shared AES constants, FSM/update encodings and round-transform helpers
// used by the encipher and decipher round blocks.
package aes_pkg;

   localparam logic [1:0] KEYLEN_128 = 2'd0;
   localparam logic [1:0] KEYLEN_192 = 2'd1;
   localparam logic [1:0] KEYLEN_256 = 2'd2;

   localparam logic [3:0] AES128_ROUNDS = 4'd10;
   localparam logic [3:0] AES192_ROUNDS = 4'd12;
   localparam logic [3:0] AES256_ROUNDS = 4'd14;

   typedef enum logic [1:0] {
      CTRL_IDLE,
      CTRL_INIT,
      CTRL_SBOX,
      CTRL_MAIN
   } ctrl_e;

   typedef enum logic [2:0] {
      UPD_NONE,
      UPD_INIT,
      UPD_SBOX,
      UPD_MAIN,
      UPD_FINAL
   } upd_e;

   // Code 3 is not a real key size and falls back to AES-128.
   function automatic logic [3:0] num_rounds(input logic [1:0] klen);
      case (klen)
         KEYLEN_192: num_rounds = AES192_ROUNDS;
         KEYLEN_256: num_rounds = AES256_ROUNDS;
         default:    num_rounds = AES128_ROUNDS;
      endcase
   endfunction

   function automatic logic [7:0] gm2(input logic [7:0] b);
      gm2 = {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
   endfunction

   function automatic logic [7:0] gm3(input logic [7:0] b);
      gm3 = gm2(b) ^ b;
   endfunction

   function automatic logic [31:0] mixw(input logic [31:0] w);
      logic [7:0] b0, b1, b2, b3;
      {b0, b1, b2, b3} = w;
      mixw = {gm2(b0) ^ gm3(b1) ^ b2 ^ b3,
              b0 ^ gm2(b1) ^ gm3(b2) ^ b3,
              b0 ^ b1 ^ gm2(b2) ^ gm3(b3),
              gm3(b0) ^ b1 ^ b2 ^ gm2(b3)};
   endfunction

   function automatic logic [127:0] mixcolumns(input logic [127:0] s);
      mixcolumns = {mixw(s[127:96]), mixw(s[95:64]),
                    mixw(s[63:32]), mixw(s[31:0])};
   endfunction

   // Word c is column c; the MSB byte of a word is row 0.
   function automatic logic [127:0] shiftrows(input logic [127:0] s);
      logic [31:0] w0, w1, w2, w3;
      {w0, w1, w2, w3} = s;
      shiftrows = {w0[31:24], w1[23:16], w2[15:8], w3[7:0],
                   w1[31:24], w2[23:16], w3[15:8], w0[7:0],
                   w2[31:24], w3[23:16], w0[15:8], w1[7:0],
                   w3[31:24], w0[23:16], w1[15:8], w2[7:0]};
   endfunction

   function automatic logic [127:0] addroundkey(input logic [127:0] s,
                                                input logic [127:0] k);
      addroundkey = s ^ k;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box for one 32-bit word: four independent byte lookups,
// purely combinational.
module aes_sbox (
   input  logic [31:0] word,
   output logic [31:0] new_word
);

   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign new_word = {SBOX[word[31:24]], SBOX[word[23:16]],
                      SBOX[word[15:8]],  SBOX[word[7:0]]};

endmodule

// File: rtl/aes_encipher_block.sv
// Iterative AES forward-cipher round engine with word-serial S-box;
// define AES_ENC_PARALLEL_SBOX_EN to substitute all four words per cycle.
module aes_encipher_block
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         reset_n,
   input  logic         next,
   input  logic [1:0]   keylen,
   output logic [3:0]   round,
   input  logic [127:0] round_key,
   input  logic [127:0] block,
   output logic [127:0] new_block,
   output logic         ready
);

   ctrl_e        state, state_nxt;
   upd_e         upd;
   logic [3:0]   round_ctr, round_nxt;
   logic [1:0]   keylen_reg, keylen_nxt;
   logic         ready_reg, ready_nxt;
   logic [127:0] block_reg, block_nxt;
   logic [127:0] sub_block;
   logic         sbox_last;

`ifdef AES_ENC_PARALLEL_SBOX_EN
   for (genvar i = 0; i < 4; i++) begin : g_sbox
      aes_sbox u_sbox (
         .word     (block_reg[32*i +: 32]),
         .new_word (sub_block[32*i +: 32])
      );
   end

   assign sbox_last = 1'b1;
`else
   logic [1:0]  sword_ctr, sword_nxt;
   logic [31:0] sword, new_sword;

   aes_sbox u_sbox (
      .word     (sword),
      .new_word (new_sword)
   );

   // Only the word under sword_ctr is replaced; the rest pass through.
   always_comb begin
      sword     = block_reg[127:96];
      sub_block = block_reg;
      unique case (sword_ctr)
         2'd0: begin
            sword              = block_reg[127:96];
            sub_block[127:96]  = new_sword;
         end
         2'd1: begin
            sword              = block_reg[95:64];
            sub_block[95:64]   = new_sword;
         end
         2'd2: begin
            sword              = block_reg[63:32];
            sub_block[63:32]   = new_sword;
         end
         default: begin
            sword              = block_reg[31:0];
            sub_block[31:0]    = new_sword;
         end
      endcase
   end

   assign sbox_last = (sword_ctr == 2'd3);

   always_comb begin
      sword_nxt = sword_ctr;
      if (upd == UPD_INIT)
         sword_nxt = 2'd0;
      else if (upd == UPD_SBOX)
         sword_nxt = sword_ctr + 2'd1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         sword_ctr <= 2'd0;
      else
         sword_ctr <= sword_nxt;
   end
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= CTRL_IDLE;
         round_ctr  <= 4'd0;
         keylen_reg <= 2'd0;
         ready_reg  <= 1'b1;
         block_reg  <= 128'd0;
      end else begin
         state      <= state_nxt;
         round_ctr  <= round_nxt;
         keylen_reg <= keylen_nxt;
         ready_reg  <= ready_nxt;
         block_reg  <= block_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      round_nxt  = round_ctr;
      keylen_nxt = keylen_reg;
      ready_nxt  = ready_reg;
      upd        = UPD_NONE;
      unique case (state)
         CTRL_IDLE: begin
            if (next) begin
               keylen_nxt = keylen;
               round_nxt  = 4'd0;
               ready_nxt  = 1'b0;
               state_nxt  = CTRL_INIT;
            end
         end
         CTRL_INIT: begin
            upd       = UPD_INIT;
            round_nxt = 4'd1;
            state_nxt = CTRL_SBOX;
         end
         CTRL_SBOX: begin
            upd = UPD_SBOX;
            if (sbox_last)
               state_nxt = CTRL_MAIN;
         end
         default: begin
            if (round_ctr < num_rounds(keylen_reg)) begin
               upd       = UPD_MAIN;
               round_nxt = round_ctr + 4'd1;
               state_nxt = CTRL_SBOX;
            end else begin
               upd       = UPD_FINAL;
               ready_nxt = 1'b1;
               state_nxt = CTRL_IDLE;
            end
         end
      endcase
   end

   always_comb begin
      block_nxt = block_reg;
      case (upd)
         UPD_INIT:  block_nxt = addroundkey(block, round_key);
         UPD_SBOX:  block_nxt = sub_block;
         UPD_MAIN:  block_nxt = addroundkey(mixcolumns(shiftrows(block_reg)),
                                            round_key);
         UPD_FINAL: block_nxt = addroundkey(shiftrows(block_reg), round_key);
         default:   block_nxt = block_reg;
      endcase
   end

   assign round     = round_ctr;
   assign new_block = block_reg;
   assign ready     = ready_reg;

endmodule

// File: doc/aes_encipher_block.md
Name: aes_encipher_block

Overview:
- Iterative AES forward-cipher round engine; the encrypt-direction counterpart of the decipher round block in the AES core.
- Takes a 128-bit plaintext block and produces the ciphertext.
- Runs the initial AddRoundKey, Nr-1 main rounds and one final round.
- Requests round keys by index from the shared key memory.
- Uses a word-serial S-box: one 32-bit word per cycle.

Parameters:
- none (round counts are package constants)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- next  in  1  start pulse; sampled only in IDLE
- keylen  in  2  0=AES-128, 1=AES-192, 2=AES-256, 3=treated as AES-128; latched when next is accepted
- round  out  4  index of the round key needed this cycle
- round_key  in  128  key for the index on round; must be valid combinationally in the same cycle
- block  in  128  plaintext; sampled in INIT only
- new_block  out  128  state/result register; holds ciphertext when ready=1
- ready  out  1  1 = idle, new_block valid

Behaviour:
- Reset (async, any time, including mid-operation):
  - ready=1, new_block=0, round=0, sword_ctr=0, keylen_reg=0, FSM=IDLE.
  - Operation in progress is abandoned.
- States: IDLE, INIT, SBOX, MAIN.
- IDLE:
  - On next=1: latch keylen, round_ctr=0, ready<=0, go to INIT.
  - next=0: hold all registers.
- INIT:
  - new_block <= block ^ round_key (key 0).
  - round_ctr <= 1, sword_ctr <= 0, go to SBOX.
- SBOX:
  - Substitute word sword_ctr (w0 = bits 127:96 first) through the S-box; only that word is written.
  - sword_ctr increments each cycle, wrapping 3->0.
  - On sword_ctr==3, go to MAIN.
- MAIN, round_ctr < Nr:
  - new_block <= AddRoundKey(MixColumns(ShiftRows(state)), round_key).
  - round_ctr++, go to SBOX.
- MAIN, round_ctr == Nr (final):
  - new_block <= ShiftRows(state) ^ round_key.
  - ready <= 1, go to IDLE; round holds Nr.
- Nr = 10/12/14, from the latched keylen.
- ShiftRows: row r of the column-major state rotates left by r columns; byte 0 of each word is row 0.
- MixColumns: GF(2^8) with polynomial 0x11b, coefficients {02,03,01,01} rotated per row.
- Busy cycles (first INIT cycle through the cycle ready returns high): 1+5*Nr, i.e. 51 / 61 / 71.
- next while ready=0 is ignored; no queuing.
- keylen and block may change while busy without effect, except block, which must be stable during the INIT cycle.

Optional Feature:
- AES_ENC_PARALLEL_SBOX_EN defined:
  - Four 32-bit S-box instances; SBOX is one cycle and substitutes all 128 bits.
  - sword_ctr is removed.
  - Busy cycles become 1+2*Nr (21 / 25 / 29).
- Undefined: word-serial behaviour as above.
- Ciphertext is identical in both builds.

Decomposition:
- aes_pkg holds:
  - keylen codes and round counts (10/12/14)
  - FSM state encoding
  - update-type encoding
  - gm2/gm3, shiftrows, mixcolumns and addroundkey functions, shared with the decipher block
- One sub-module is natural: aes_sbox (32-bit word in, 32-bit word out, four byte lookups, purely combinational).
- It is instantiated once, or four times under AES_ENC_PARALLEL_SBOX_EN.

Test Plan:
- FIPS-197 App. B:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, block 3243f6a8885a308d313198a2e0370734, keylen=0; the bench model serves round_key[round].
  - Response: new_block=3925841d02dc09fbdc118597196a0b32, ready rises exactly 51 cycles after INIT starts.
- FIPS-197 C.1/C.2/C.3:
  - Stimulus: key 000102..0f / ..17 / ..1f, block 00112233445566778899aabbccddeeff.
  - Response: 69c4e0d86a7b0430d8cdb78070b4c55a, dda97ca4864cdfe06eaf70a0ec0d7191, 8ea2b7ca516745bfeafc49904b496089, with latencies 51/61/71.
- Round sequencing: round output reads 0,1(x5),...,Nr in order and holds Nr after completion; keylen=3 behaves exactly like keylen=0.
- Start gating:
  - next asserted mid-operation and keylen changed mid-operation: no effect on result or latency.
  - Back-to-back next in the cycle ready rises: second encryption starts correctly.
- Reset mid-round:
  - Stimulus: reset_n=0 during round 5.
  - Response: ready=1, new_block=0, round=0 immediately; the next encryption is correct.
- With AES_ENC_PARALLEL_SBOX_EN: repeat the App. B vector; same ciphertext, ready after 21 cycles.
